pe1_writeback: RTL and testbench
================================

# pe1_writeback

Write-back aligner for the PE1 butterfly path. It captures the bank addresses of each operand pair issued to PE1 and delays them by the PE1 pipeline latency of the active Kyber/Dilithium NTT/INTT mode. It then pairs them with `PE1_out1`/`PE1_out2` to produce aligned bank write strobes. It sits between the operand address generator and the coefficient memory banks, and reports when a pass has fully drained.

## Interface
Parameters:
- `ADDR_W`, 6: bank word address width.
- `DATA_W`, 24: PE1 output / bank word width (two 12-bit Kyber coefficients or one 24-bit Dilithium coefficient).
- `LAT_K_NTT`, 7: PE1 latency for K_2_NTT and K_4_NTT.
- `LAT_K2_INTT`, 8: latency for K_2_INTT.
- `LAT_K4_INTT`, 21: latency for K_4_INTT.
- `LAT_D_NTT`, 7: latency for D_2_NTT.
- `LAT_D_INTT`, 8: latency for D_2_INTT.
- `MAX_LAT`, 21: delay-line depth; must be ≥ every LAT_*.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `sel_0`, `sel_1`, `KD_mode`, in, 1 each: PE1 mode bits, same encoding PE1 uses.
- `in_valid`, in, 1: an operand pair is issued to PE1 this cycle.
- `in_ready`, out, 1: the block accepts issues.
- `in_addr1`, `in_addr2`, in, ADDR_W each: destination addresses for out1/out2 of this issue.
- `in_last`, in, 1: final issue of the pass.
- `PE1_out1`, `PE1_out2`, in, DATA_W each: PE1 results.
- `wr_en`, out, 1: write strobe.
- `wr_addr1`, `wr_addr2`, out, ADDR_W each: write addresses.
- `wr_data1`, `wr_data2`, out, DATA_W each: write data.
- `busy`, out, 1: a pass is in progress.
- `done`, out, 1: one-cycle pulse when a pass completes.

## Operation
- Mode decode: `KD_mode=1` selects `sel_1 ? LAT_D_INTT : LAT_D_NTT`, and `sel_0` is ignored. `KD_mode=0, sel_1=0` selects LAT_K_NTT. `KD_mode=0, sel_1=1` selects `sel_0 ? LAT_K4_INTT : LAT_K2_INTT`.
- The mode bits are latched at the issue that moves IDLE→RUN. They are ignored for the rest of the pass.
- Delay line: MAX_LAT-stage shift register carrying {valid, addr1, addr2, last}. Stage 0 loads the accepted issue, or zeros if there is none. The output tap is stage LAT−1 for the latched latency LAT.
- A tap with valid=1 produces `wr_en=1`, the tap addresses, and `wr_data1/2 = PE1_out1/2` taken combinationally from the same cycle.
- States:
  - IDLE: `in_ready=1`. An accepted issue latches the mode and goes to RUN. If that first issue also has `in_last=1`, go directly to DRAIN.
  - RUN: `in_ready=1`. An accepted issue with `in_last=1` goes to DRAIN.
  - DRAIN: `in_ready=0`; `in_valid` is ignored. When the tap shows valid with last=1, go to DONE.
  - DONE: `done=1` for one cycle, then go to IDLE.
- `busy=1` in RUN, DRAIN and DONE.
- An in-flight counter (width ⌈log2(MAX_LAT+1)⌉) increments on accept and decrements on write. An increment and decrement in the same cycle leave it unchanged. The counter must be 0 when DONE is entered. A nonzero value is an assertion failure in simulation.
- Gaps in `in_valid` are allowed in RUN and produce matching gaps in `wr_en`.
- Address collisions and data content are not checked.

## Timing
- An issue accepted at cycle t produces `wr_en` at cycle t+LAT. Writes stay in issue order.
- `done` asserts the cycle after the last write. The earliest next accept is the cycle after `done`.
- Reset: the delay line, counter and state clear to IDLE. Outputs reset to `wr_en=0`, `done=0`, `busy=0`, `in_ready=1`, and addresses/data = 0 (data is muxed to 0 when `wr_en=0`).
- Reset mid-pass discards all in-flight entries. No write and no `done` occur after reset.
- Mode bits changing during RUN/DRAIN have no effect on the tap.

## Structure
- Shared package: the mode enum {K_NTT, K2_INTT, K4_INTT, D_NTT, D_INTT}, the mode-decode function, and the FSM state typedef.
- One sub-module, `wb_delay_line`: a parameterised-depth shift register with a runtime tap select.
- FSM, counter and output muxing stay in the top.

## Test plan
- K_2_NTT, 32 back-to-back issues, addr1=i, addr2=i+32, last on i=31. Expect `wr_en` at cycles 7..38 after the first issue with matching addresses and data, `done` at cycle 39.
- K_4_INTT, 4 issues with a 2-cycle gap after the 2nd. Expect writes at t+21 with the same gap, then `done` one cycle after the 4th write.
- D_2_INTT, single issue with `in_last=1` in IDLE. Expect direct entry to DRAIN, one write 8 cycles later, then `done`.
- Toggle `KD_mode` 0→1 mid-RUN of a K_NTT pass. Expect latency to stay 7 and all writes to be correct.
- `in_valid=1` during DRAIN. Expect `in_ready=0`, no extra write, and the counter never exceeding the issue count.
- Assert `rst` with 5 entries in flight. Expect no `wr_en` afterwards, no `done`, and all outputs 0 / `in_ready=1` on the next cycle.

Source files
------------

// File: rtl/pe1_writeback_pkg.sv
// pe1_writeback_pkg: shared mode/state types and PE1 mode decode
package pe1_writeback_pkg;
    typedef enum logic [2:0] {K_NTT, K2_INTT, K4_INTT, D_NTT, D_INTT} mode_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    // Dilithium ignores sel_0; Kyber NTT ignores sel_0 as well
    function automatic mode_t decode_mode(input logic kd, input logic s1, input logic s0);
        return kd ? (s1 ? D_INTT : D_NTT) : (s1 ? (s0 ? K4_INTT : K2_INTT) : K_NTT);
    endfunction
endpackage

// File: rtl/pe1_writeback_if.sv
// pe1_writeback_if: issue side (mode, valid/ready, addresses, last), PE1 results, write-back side (wr_*), busy/done
interface pe1_writeback_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 24
);
    logic              sel_0, sel_1, KD_mode;
    logic              in_valid, in_ready, in_last;
    logic [ADDR_W-1:0] in_addr1, in_addr2;
    logic [DATA_W-1:0] PE1_out1, PE1_out2;
    logic              wr_en, busy, done;
    logic [ADDR_W-1:0] wr_addr1, wr_addr2;
    logic [DATA_W-1:0] wr_data1, wr_data2;
    modport slave (
        input  sel_0, sel_1, KD_mode, in_valid, in_last, in_addr1, in_addr2, PE1_out1, PE1_out2,
        output in_ready, wr_en, wr_addr1, wr_addr2, wr_data1, wr_data2, busy, done
    );
    modport master (
        output sel_0, sel_1, KD_mode, in_valid, in_last, in_addr1, in_addr2, PE1_out1, PE1_out2,
        input  in_ready, wr_en, wr_addr1, wr_addr2, wr_data1, wr_data2, busy, done
    );
endinterface

// File: rtl/pe1_writeback_delay.sv
// wb_delay_line: DEPTH-stage shift register with runtime output tap
// Ports: clk, rst (sync clear), clr (sync clear), d (stage 0 input), tap (stage index), q (tapped stage)
module wb_delay_line #(
    parameter int DEPTH = 21,
    parameter int W     = 14,
    parameter int TW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [W-1:0]  d,
    input  logic [TW-1:0] tap,
    output logic [W-1:0]  q
);
    logic [W-1:0] sr_q [DEPTH];
    logic [W-1:0] sr_d [DEPTH];
    always_comb begin
        sr_d[0] = d;
        for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= (rst || clr) ? '0 : sr_d[i];
    end
    assign q = sr_q[tap];
endmodule

// File: rtl/pe1_writeback.sv
// pe1_writeback: delays PE1 issue addresses by the mode latency and pairs them with PE1 results
// Ports: clk, rst (sync, active-high), bus (pe1_writeback_if.slave: issue, PE1 results, write-back, busy/done)
module pe1_writeback
    import pe1_writeback_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 24,
    parameter int LAT_K_NTT   = 7,
    parameter int LAT_K2_INTT = 8,
    parameter int LAT_K4_INTT = 21,
    parameter int LAT_D_NTT   = 7,
    parameter int LAT_D_INTT  = 8,
    parameter int MAX_LAT     = 21
) (
    input logic             clk,
    input logic             rst,
    pe1_writeback_if.slave  bus
);
    localparam int CW = $clog2(MAX_LAT + 1);
    localparam int TW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int EW = 2 * ADDR_W + 2;
    state_t         state_q, state_d;
    mode_t          mode_q, mode_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           accept, wr, tap_last;
    logic [EW-1:0]  ent_in, ent_out;
    logic [TW-1:0]  tap;
    int unsigned    lat;
    always_comb begin
        lat = mode_q == K_NTT   ? LAT_K_NTT   :
              mode_q == K2_INTT ? LAT_K2_INTT :
              mode_q == K4_INTT ? LAT_K4_INTT :
              mode_q == D_NTT   ? LAT_D_NTT   : LAT_D_INTT;
        tap = TW'(lat - 1);
        bus.in_ready = state_q == IDLE || state_q == RUN;
        accept = bus.in_valid && bus.in_ready;
        ent_in = accept ? {1'b1, bus.in_addr1, bus.in_addr2, bus.in_last} : '0;
        wr = ent_out[EW-1];
        tap_last = ent_out[0];
        state_d = state_q == IDLE  ? (accept ? (bus.in_last ? DRAIN : RUN) : IDLE) :
                  state_q == RUN   ? (accept && bus.in_last ? DRAIN : RUN) :
                  state_q == DRAIN ? (wr && tap_last ? DONE : DRAIN) : IDLE;
        mode_d = (state_q == IDLE && accept) ? decode_mode(bus.KD_mode, bus.sel_1, bus.sel_0) : mode_q;
        cnt_d = cnt_q + CW'(accept) - CW'(wr);
        bus.wr_en = wr;
        bus.wr_addr1 = wr ? ent_out[EW-2 -: ADDR_W] : '0;
        bus.wr_addr2 = wr ? ent_out[ADDR_W:1] : '0;
        bus.wr_data1 = wr ? bus.PE1_out1 : '0;
        bus.wr_data2 = wr ? bus.PE1_out2 : '0;
        bus.busy = state_q != IDLE;
        bus.done = state_q == DONE;
    end
    always_ff @(posedge clk) begin
        state_q <= rst ? IDLE : state_d;
        mode_q <= rst ? K_NTT : mode_d;
        cnt_q <= rst ? '0 : cnt_d;
    end
    // Entries past the tap of a finished pass would reappear under a longer
    // latency in the next pass, so the line is flushed while in DONE.
    wb_delay_line #(.DEPTH(MAX_LAT), .W(EW), .TW(TW)) u_dl (
        .clk(clk),
        .rst(rst),
        .clr(state_q == DONE),
        .d(ent_in),
        .tap(tap),
        .q(ent_out)
    );
    always @(posedge clk) begin
        if (!rst && state_q == DONE) assert (cnt_q == '0);
    end
endmodule

// File: tb/tb_pe1_writeback.sv
// tb_pe1_writeback: self-checking bench with a scheduled-write reference model
module tb_pe1_writeback;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    pe1_writeback_if #(.ADDR_W(6), .DATA_W(24)) bus();
    pe1_writeback dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {int due; logic [5:0] a1; logic [5:0] a2; logic last;} wr_t;
    typedef struct {logic kd; logic s1; logic s0; int lat;} vec_t;
    wr_t  q[$];
    vec_t vecs[8];
    int n_chk = 0, n_err = 0, cyc = 0, m_lat = 0, m_done_at = -1;
    int obs_cyc = 0, wr_seen = 0, done_seen = 0, t0, w0, d0;
    bit m_busy = 0, m_drain = 0, obs_wr = 0, obs_done = 0;
    function automatic int model_lat(logic kd, logic s1, logic s0);
        if (kd) return s1 ? 8 : 7;
        if (!s1) return 7;
        return s0 ? 21 : 8;
    endfunction
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic step();
        bit e_wr, e_done, e_ready;
        logic [5:0] ea1, ea2;
        logic [23:0] p1, p2;
        p1 = 24'($urandom);
        p2 = 24'($urandom);
        bus.PE1_out1 = p1;
        bus.PE1_out2 = p2;
        @(negedge clk);
        e_wr = q.size() > 0 && q[0].due == cyc;
        e_done = cyc == m_done_at;
        e_ready = !m_drain && !e_done;
        ea1 = 0;
        ea2 = 0;
        if (e_wr) begin ea1 = q[0].a1; ea2 = q[0].a2; end
        obs_cyc = cyc;
        obs_wr = 0;
        obs_done = 0;
        if (!rst) begin
            chk("wr_en", bus.wr_en, e_wr);
            chk("wr_addr1", bus.wr_addr1, ea1);
            chk("wr_addr2", bus.wr_addr2, ea2);
            chk("wr_data1", bus.wr_data1, e_wr ? p1 : 24'd0);
            chk("wr_data2", bus.wr_data2, e_wr ? p2 : 24'd0);
            chk("in_ready", bus.in_ready, e_ready);
            chk("busy", bus.busy, m_busy);
            chk("done", bus.done, e_done);
            chk("inflight", dut.cnt_q, q.size());
            obs_wr = bus.wr_en;
            obs_done = bus.done;
            wr_seen += int'(obs_wr);
            done_seen += int'(obs_done);
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_busy = 0;
            m_drain = 0;
            m_done_at = -1;
        end else begin
            if (e_done) begin m_busy = 0; m_done_at = -1; end
            if (e_wr) begin
                if (q[0].last) begin m_drain = 0; m_done_at = cyc + 1; end
                void'(q.pop_front());
            end
            if (e_ready && bus.in_valid) begin
                if (!m_busy) m_lat = model_lat(bus.KD_mode, bus.sel_1, bus.sel_0);
                m_busy = 1;
                q.push_back('{cyc + m_lat, bus.in_addr1, bus.in_addr2, bus.in_last});
                if (bus.in_last) m_drain = 1;
            end
        end
        cyc++;
        #1;
    endtask
    task automatic issue(logic [5:0] a1, logic [5:0] a2, logic last);
        bus.in_valid = 1;
        bus.in_addr1 = a1;
        bus.in_addr2 = a2;
        bus.in_last = last;
        step();
        bus.in_valid = 0;
        bus.in_last = 0;
    endtask
    task automatic idle(int n);
        repeat (n) step();
    endtask
    task automatic wait_done();
        for (int k = 0; k < 80 && !obs_done; k++) step();
    endtask
    task automatic drain();
        for (int k = 0; k < 80 && (m_busy || bus.busy); k++) step();
        chk("drain_idle", bus.busy, 0);
    endtask
    task automatic set_mode(logic kd, logic s1, logic s0);
        bus.KD_mode = kd;
        bus.sel_1 = s1;
        bus.sel_0 = s0;
    endtask
    initial begin
        int n;
        vecs = '{'{0, 0, 0, 7}, '{0, 0, 1, 7}, '{0, 1, 0, 8}, '{0, 1, 1, 21},
                 '{1, 0, 0, 7}, '{1, 0, 1, 7}, '{1, 1, 0, 8}, '{1, 1, 1, 8}};
        set_mode(0, 0, 0);
        bus.in_valid = 0;
        bus.in_last = 0;
        bus.in_addr1 = 0;
        bus.in_addr2 = 0;
        step();
        step();
        rst = 0;
        step();
        for (int i = 0; i < 8; i++) begin
            set_mode(vecs[i].kd, vecs[i].s1, vecs[i].s0);
            issue(6'($urandom), 6'($urandom), 1);
            n = 0;
            while (!obs_wr && n < 40) begin step(); n++; end
            chk($sformatf("lat_vec%0d", i), n, vecs[i].lat);
            drain();
        end
        set_mode(0, 0, 0);
        t0 = cyc;
        w0 = wr_seen;
        for (int i = 0; i < 32; i++) issue(6'(i), 6'(i + 32), i == 31);
        wait_done();
        chk("k2_done_at", obs_cyc - t0, 39);
        chk("k2_writes", wr_seen - w0, 32);
        drain();
        set_mode(0, 1, 1);
        t0 = cyc;
        issue(1, 2, 0);
        issue(3, 4, 0);
        idle(2);
        issue(5, 6, 0);
        issue(7, 8, 1);
        wait_done();
        chk("k4_done_at", obs_cyc - t0, 27);
        drain();
        set_mode(0, 0, 0);
        t0 = cyc;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) set_mode(1, 1, 0);
            issue(6'(10 + i), 6'(40 + i), i == 5);
        end
        wait_done();
        chk("toggle_done_at", obs_cyc - t0, 13);
        drain();
        set_mode(0, 0, 0);
        t0 = cyc;
        w0 = wr_seen;
        issue(20, 21, 0);
        issue(22, 23, 1);
        bus.in_valid = 1;
        wait_done();
        bus.in_valid = 0;
        chk("drainv_done_at", obs_cyc - t0, 9);
        chk("drainv_writes", wr_seen - w0, 2);
        drain();
        for (int i = 0; i < 5; i++) issue(6'(i), 6'(i), 0);
        rst = 1;
        step();
        rst = 0;
        w0 = wr_seen;
        d0 = done_seen;
        idle(30);
        chk("rst_no_write", wr_seen - w0, 0);
        chk("rst_no_done", done_seen - d0, 0);
        for (int p = 0; p < 8; p++) begin
            set_mode(1'($urandom), 1'($urandom), 1'($urandom));
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                idle($urandom_range(0, 2));
                issue(6'($urandom), 6'($urandom), i == n - 1);
                set_mode(1'($urandom), 1'($urandom), 1'($urandom));
            end
            drain();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
